id_ex_hold_reg: RTL and testbench

//  ID/EX pipeline register and the consumer of the hazard-stall decision. On Stall it freezes PC and
//  IF/ID and injects a bubble into EX that keeps the stalled instruction's PC/BD for correct EPC.
//  On Flush (exception/interrupt entry) it clears EX with a handler-PC bubble.

---
 rtl/id_ex_hold_reg_pkg.sv | 11 +
 rtl/id_ex_hold_reg_sat_counter.sv | 32 +++
 rtl/id_ex_hold_reg.sv | 126 ++++++++++++
 tb/tb_id_ex_hold_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_hold_reg_pkg.sv
// Shared constants and FSM state type for the ID/EX hold register.
package id_ex_hold_reg_pkg;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER_DEF = 32'h0000_4180;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hold_state_e;
endpackage

// File: rtl/id_ex_hold_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/id_ex_hold_reg.sv
// ID/EX pipeline register: stall bubbles keep the stalled PC/BD, flush bubbles carry the handler PC.
// Hold_dbg mirrors the RUN/HOLD state for debug visibility.
module id_ex_hold_reg
    import id_ex_hold_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
    parameter logic [31:0] PC_HANDLER = PC_HANDLER_DEF,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [31:0]      Instr_ID,
    input  logic [31:0]      PC_ID,
    input  logic             BD_ID,
    input  logic [4:0]       RegA3_ID,
    input  logic [31:0]      RD1_ID,
    input  logic [31:0]      RD2_ID,
    input  logic [31:0]      Ext_ID,
    output logic             PC_en,
    output logic             IFID_en,
    output logic [31:0]      Instr_EX,
    output logic [31:0]      PC_EX,
    output logic             BD_EX,
    output logic [4:0]       RegA3_EX,
    output logic [31:0]      RD1_EX,
    output logic [31:0]      RD2_EX,
    output logic [31:0]      Ext_EX,
    output logic [CNT_W-1:0] StallEvt_cnt,
    output logic [CNT_W-1:0] StallCyc_cnt,
    output logic             Hold_dbg
);
    hold_state_e state_q, state_d;
    logic [31:0] instr_q, instr_d, pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, ext_q, ext_d;
    logic        bd_q, bd_d;
    logic [4:0]  a3_q, a3_d;
    logic        stall_only;
    logic        evt_en;

    // A flush always wins, so a stall only takes effect when no flush is pending.
    assign stall_only = Stall & ~Flush;
    assign PC_en      = ~Stall | Flush;
    assign IFID_en    = ~Stall | Flush;

    always_comb begin
        instr_d = Instr_ID;
        pc_d    = PC_ID;
        bd_d    = BD_ID;
        a3_d    = RegA3_ID;
        rd1_d   = RD1_ID;
        rd2_d   = RD2_ID;
        ext_d   = Ext_ID;
        if (Flush) begin
            instr_d = NOP_INSTR;
            pc_d    = PC_HANDLER;
            bd_d    = 1'b0;
            a3_d    = 5'd0;
            rd1_d   = 32'h0;
            rd2_d   = 32'h0;
            ext_d   = 32'h0;
        end else if (Stall) begin
            instr_d = NOP_INSTR;
            a3_d    = 5'd0;
            rd1_d   = 32'h0;
            rd2_d   = 32'h0;
            ext_d   = 32'h0;
        end
    end

    always_comb begin
        state_d = RUN;
        evt_en  = 1'b0;
        if (stall_only) begin
            state_d = HOLD;
            evt_en  = (state_q == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            instr_q <= NOP_INSTR;
            pc_q    <= PC_RESET;
            bd_q    <= 1'b0;
            a3_q    <= 5'd0;
            rd1_q   <= 32'h0;
            rd2_q   <= 32'h0;
            ext_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            a3_q    <= a3_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ext_q   <= ext_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (evt_en),
        .cnt_o (StallEvt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (stall_only),
        .cnt_o (StallCyc_cnt)
    );

    assign Instr_EX = instr_q;
    assign PC_EX    = pc_q;
    assign BD_EX    = bd_q;
    assign RegA3_EX = a3_q;
    assign RD1_EX   = rd1_q;
    assign RD2_EX   = rd2_q;
    assign Ext_EX   = ext_q;
    assign Hold_dbg = (state_q == HOLD);
endmodule

// File: tb/tb_id_ex_hold_reg.sv
// Directed bench for id_ex_hold_reg: vector table plus multi-cycle stall/flush/reset sequences.
module tb_id_ex_hold_reg;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, Stall, Flush, BD_ID;
    logic [31:0]      Instr_ID, PC_ID, RD1_ID, RD2_ID, Ext_ID;
    logic [4:0]       RegA3_ID;
    logic             PC_en, IFID_en, BD_EX, Hold_dbg;
    logic [31:0]      Instr_EX, PC_EX, RD1_EX, RD2_EX, Ext_EX;
    logic [4:0]       RegA3_EX;
    logic [CNT_W-1:0] StallEvt_cnt, StallCyc_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_hold_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .Instr_ID(Instr_ID), .PC_ID(PC_ID), .BD_ID(BD_ID), .RegA3_ID(RegA3_ID),
        .RD1_ID(RD1_ID), .RD2_ID(RD2_ID), .Ext_ID(Ext_ID),
        .PC_en(PC_en), .IFID_en(IFID_en), .Instr_EX(Instr_EX), .PC_EX(PC_EX),
        .BD_EX(BD_EX), .RegA3_EX(RegA3_EX), .RD1_EX(RD1_EX), .RD2_EX(RD2_EX),
        .Ext_EX(Ext_EX), .StallEvt_cnt(StallEvt_cnt), .StallCyc_cnt(StallCyc_cnt),
        .Hold_dbg(Hold_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush;
        logic [31:0] instr, pc;
        logic        bd;
        logic [4:0]  a3;
        logic [31:0] rd1, rd2, ext;
        logic        x_en;
        logic [31:0] x_instr, x_pc;
        logic        x_bd;
        logic [4:0]  x_a3;
        logic [31:0] x_rd1, x_rd2, x_ext;
        int          x_evt, x_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs at negedge, check enables combinationally, then let one edge pass.
    task automatic step(input logic s, input logic f, input logic [31:0] ins, input logic [31:0] pc,
                        input logic bd, input logic [4:0] a3, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] e, input logic x_en);
        @(negedge clk);
        Stall = s; Flush = f; Instr_ID = ins; PC_ID = pc; BD_ID = bd;
        RegA3_ID = a3; RD1_ID = r1; RD2_ID = r2; Ext_ID = e;
        #1;
        chk("PC_en", {31'd0, PC_en}, {31'd0, x_en});
        chk("IFID_en", {31'd0, IFID_en}, {31'd0, x_en});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int evt, input int cyc);
        chk({tag, ".StallEvt"}, 32'(StallEvt_cnt), evt[31:0]);
        chk({tag, ".StallCyc"}, 32'(StallCyc_cnt), cyc[31:0]);
    endtask

    initial begin
        //          stall flush instr         pc          bd a3 rd1    rd2    ext   en  x_instr       x_pc         bd a3 rd1    rd2    ext   evt cyc
        vecs[0] = '{1'b0, 1'b0, 32'h8C01_0000, 32'h3004, 1'b0, 5'd1, 32'h11, 32'h22, 32'h4, 1'b1,
                    32'h8C01_0000, 32'h3004, 1'b0, 5'd1, 32'h11, 32'h22, 32'h4, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h0021_1020, 32'h3008, 1'b0, 5'd2, 32'h5, 32'h6, 32'h7, 1'b0,
                    32'h0, 32'h3008, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h0021_1020, 32'h3008, 1'b0, 5'd2, 32'h5, 32'h6, 32'h7, 1'b1,
                    32'h0021_1020, 32'h3008, 1'b0, 5'd2, 32'h5, 32'h6, 32'h7, 1, 1};
        vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 32'h300C, 1'b1, 5'd9, 32'h9, 32'h9, 32'h9, 1'b1,
                    32'h0, 32'h4180, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 1};
        vecs[4] = '{1'b1, 1'b1, 32'h2345_6789, 32'h3010, 1'b1, 5'd3, 32'h1, 32'h2, 32'h3, 1'b1,
                    32'h0, 32'h4180, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'hAC03_0010, 32'h3014, 1'b1, 5'd4, 32'hA, 32'hB, 32'hC, 1'b0,
                    32'h0, 32'h3014, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 2, 2};
        vecs[6] = '{1'b0, 1'b1, 32'hAC03_0010, 32'h3014, 1'b1, 5'd4, 32'hA, 32'hB, 32'hC, 1'b1,
                    32'h0, 32'h4180, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2, 2};

        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Instr_ID = 32'h0; PC_ID = 32'h0;
        BD_ID = 1'b0; RegA3_ID = 5'd0; RD1_ID = 32'h0; RD2_ID = 32'h0; Ext_ID = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.PC_EX", PC_EX, 32'h3000);
        chk("rst.Instr_EX", Instr_EX, 32'h0);
        chk("rst.BD_EX", {31'd0, BD_EX}, 32'h0);
        chk("rst.RegA3_EX", {27'd0, RegA3_EX}, 32'h0);
        chk("rst.PC_en", {31'd0, PC_en}, 32'h1);
        chk("rst.Hold", {31'd0, Hold_dbg}, 32'h0);
        chk_cnt("rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].stall, vecs[i].flush, vecs[i].instr, vecs[i].pc, vecs[i].bd,
                 vecs[i].a3, vecs[i].rd1, vecs[i].rd2, vecs[i].ext, vecs[i].x_en);
            chk($sformatf("v%0d.Instr_EX", i), Instr_EX, vecs[i].x_instr);
            chk($sformatf("v%0d.PC_EX", i), PC_EX, vecs[i].x_pc);
            chk($sformatf("v%0d.BD_EX", i), {31'd0, BD_EX}, {31'd0, vecs[i].x_bd});
            chk($sformatf("v%0d.RegA3_EX", i), {27'd0, RegA3_EX}, {27'd0, vecs[i].x_a3});
            chk($sformatf("v%0d.RD1_EX", i), RD1_EX, vecs[i].x_rd1);
            chk($sformatf("v%0d.RD2_EX", i), RD2_EX, vecs[i].x_rd2);
            chk($sformatf("v%0d.Ext_EX", i), Ext_EX, vecs[i].x_ext);
            chk_cnt($sformatf("v%0d", i), vecs[i].x_evt, vecs[i].x_cyc);
        end

        // Three-cycle stall: one event, three cycles, identical bubbles each time.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0043_2020, 32'h3020, 1'b0, 5'd4, 32'h1, 32'h2, 32'h3, 1'b0);
            chk($sformatf("ms%0d.Instr_EX", k), Instr_EX, 32'h0);
            chk($sformatf("ms%0d.PC_EX", k), PC_EX, 32'h3020);
            chk($sformatf("ms%0d.RegA3_EX", k), {27'd0, RegA3_EX}, 32'h0);
            chk($sformatf("ms%0d.Hold", k), {31'd0, Hold_dbg}, 32'h1);
            chk_cnt($sformatf("ms%0d", k), 3, 3 + k);
        end
        step(1'b0, 1'b0, 32'h0043_2020, 32'h3020, 1'b0, 5'd4, 32'h1, 32'h2, 32'h3, 1'b1);
        chk("rel.Instr_EX", Instr_EX, 32'h0043_2020);
        chk("rel.Hold", {31'd0, Hold_dbg}, 32'h0);
        chk_cnt("rel", 3, 5);

        // Flush during HOLD returns to RUN; the next stall is a new event.
        step(1'b1, 1'b0, 32'h0, 32'h3028, 1'b0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_cnt("fh.a", 4, 6);
        step(1'b0, 1'b1, 32'h0, 32'h3028, 1'b0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("fh.PC_EX", PC_EX, 32'h4180);
        chk("fh.Hold", {31'd0, Hold_dbg}, 32'h0);
        chk_cnt("fh.b", 4, 6);
        step(1'b1, 1'b0, 32'h0, 32'h4180, 1'b0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_cnt("fh.c", 5, 7);

        // Reset mid-stall clears counters and discards the bubble.
        @(negedge clk);
        reset = 1'b1; Stall = 1'b1; PC_ID = 32'h3040;
        @(posedge clk);
        #1;
        chk("rms.PC_EX", PC_EX, 32'h3000);
        chk("rms.Hold", {31'd0, Hold_dbg}, 32'h0);
        chk_cnt("rms", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Long stall drives the 4-bit cycle counter into saturation.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 32'h0, 32'h3050, 1'b0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        end
        chk_cnt("sat", 1, 15);
        step(1'b1, 1'b0, 32'h0, 32'h3050, 1'b0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_cnt("sat2", 1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
